hazard_controller: RTL
======================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have ports IF_ID_rs1 and IF_ID_rs2, input, 5 each, source registers of the instruction in ID.
REQ-005 SHALL have ports IF_ID_use_rs1 and IF_ID_use_rs2, input, 1 each, the ID instruction reads that source.
REQ-006 SHALL have ports branch, jal and jalr, input, 1 each, the ID instruction is of that type.
REQ-007 SHALL have port branch_taken, input, 1, ID comparator result, valid only when branch=1.
REQ-008 SHALL have ports ID_EX_rd, input, 5; ID_EX_regwrite, input, 1; ID_EX_memread, input, 1.
REQ-009 SHALL have ports EX_MEM_rd, input, 5; EX_MEM_memread, input, 1.
REQ-010 SHALL have ports ICACHE_stall and DCACHE_stall, input, 1 each, cache miss in progress.
REQ-011 SHALL have ports PC_write, IF_ID_write, ID_EX_write, EX_MEM_write and MEM_WB_write, output, 1 each, pipeline register enables.
REQ-012 SHALL have ports IF_ID_flush and ID_EX_bubble, output, 1 each, zero IF/ID and inject a NOP into ID/EX.
REQ-013 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each, saturating event counters.

Function
REQ-014 SHALL compute match1 = IF_ID_use_rs1 && IF_ID_rs1 != 0 && IF_ID_rs1 == rd (same for rs2); x0 never matches.
REQ-015 SHALL treat as hazard any of: (a) load-use: ID_EX_memread && match(ID_EX_rd); (b) control-use: (branch||jalr) && ID_EX_regwrite && match(ID_EX_rd); (c) control-load: (branch||jalr) && EX_MEM_memread && match(EX_MEM_rd).
REQ-016 SHALL implement FSM states RUN, BUBBLE2, held in a register.
REQ-017 In RUN with hazard: PC_write=0, IF_ID_write=0, ID_EX_bubble=1 for that cycle; go to BUBBLE2 if (branch||jalr) && ID_EX_memread && match(ID_EX_rd), else stay RUN.
REQ-018 In BUBBLE2: same stall outputs as REQ-017 for exactly one cycle, then RUN unconditionally; combinational hazard ignored.
REQ-019 SHALL assert IF_ID_flush for one cycle when, in RUN with no hazard and no cache stall, jal || jalr || (branch && branch_taken).
REQ-020 A hazard bubble SHALL suppress IF_ID_flush in that cycle; the control instruction re-resolves in the later cycle.
REQ-021 Cache stall (ICACHE_stall||DCACHE_stall) SHALL have highest priority: all five *_write=0, IF_ID_flush=0, ID_EX_bubble=0, FSM state and counters frozen.
REQ-022 With no stall, hazard or flush, all *_write=1, IF_ID_flush=0, ID_EX_bubble=0.
REQ-023 stall_cnt SHALL increment by 1 per cycle with ID_EX_bubble=1; flush_cnt per cycle with IF_ID_flush=1; both saturate at all-ones.
REQ-024 Outputs other than counters SHALL be combinational from state and inputs; bubble-to-resume latency is zero cycles.

Reset
REQ-025 While rst_n=0 at a clock edge: state<=RUN, stall_cnt<=0, flush_cnt<=0.
REQ-026 While rst_n=0: all *_write=0, IF_ID_flush=0, ID_EX_bubble=1, regardless of other inputs.
REQ-027 Reset asserted in BUBBLE2 SHALL abandon the pending bubble; first cycle after release is RUN.

Structure
REQ-028 State encoding (RUN=1'b0, BUBBLE2=1'b1) and the x0 constant SHALL live in shared package hazard_pkg.
REQ-029 Register-match logic of REQ-014/015 SHALL be a combinational sub-module hazard_detect; FSM, counters and output muxing stay in hazard_controller.

Verification
REQ-030 lw x5 in EX (ID_EX_memread=1, rd=5), add using rs1=5 in ID -> one cycle PC_write=0, ID_EX_bubble=1, stall_cnt 0->1, then normal flow.
REQ-031 lw x7 in EX, beq rs1=7 in ID, taken -> two bubble cycles (RUN->BUBBLE2->RUN), then IF_ID_flush=1 for one cycle; stall_cnt=2, flush_cnt=1.
REQ-032 ID_EX_rd=0 with memread=1, IF_ID_rs1=0 used -> no bubble; stall_cnt remains 0.
REQ-033 DCACHE_stall=1 for 4 cycles while in BUBBLE2 -> all *_write=0 for 4 cycles, state held, then one BUBBLE2 cycle completes; stall_cnt increments only once.
REQ-034 Jal in ID with no hazard -> IF_ID_flush=1 exactly one cycle, flush_cnt+1; rst_n=0 during BUBBLE2 -> counters 0, state RUN after release.
REQ-035 Force stall_cnt to all-ones via CNT_W=4 build, 20 bubbles -> stall_cnt holds 4'hF.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Brief    : Shared FSM encoding, x0 constant and register-match helper
//             for the pipeline hazard controller.
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        BUBBLE2 = 1'b1
    } state_t;

    localparam logic [4:0] c_reg_x0 = 5'd0;

    // x0 is hardwired to zero, so it never creates a dependency
    function automatic logic reg_match(input logic use_rs, input logic [4:0] rs,
                                       input logic [4:0] rd);
        return use_rs && (rs != c_reg_x0) && (rs == rd);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_detect
//  Brief    : Combinational source/destination match producing the stall
//             request and the "needs a second bubble" qualifier.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [4:0] if_id_rs1,
    input  logic [4:0] if_id_rs2,
    input  logic       if_id_use_rs1,
    input  logic       if_id_use_rs2,
    input  logic       branch,
    input  logic       jalr,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_regwrite,
    input  logic       id_ex_memread,
    input  logic [4:0] ex_mem_rd,
    input  logic       ex_mem_memread,
    output logic       hazard,
    output logic       two_bubbles
);

    logic w_match_ex;
    logic w_match_mem;
    logic w_ctrl;
    logic w_load_use;
    logic w_ctrl_use;
    logic w_ctrl_load;

    assign w_match_ex  = reg_match(if_id_use_rs1, if_id_rs1, id_ex_rd)
                       | reg_match(if_id_use_rs2, if_id_rs2, id_ex_rd);
    assign w_match_mem = reg_match(if_id_use_rs1, if_id_rs1, ex_mem_rd)
                       | reg_match(if_id_use_rs2, if_id_rs2, ex_mem_rd);

    // Branches and jalr resolve in ID, so they also wait on ALU results
    assign w_ctrl      = branch | jalr;
    assign w_load_use  = id_ex_memread & w_match_ex;
    assign w_ctrl_use  = w_ctrl & id_ex_regwrite & w_match_ex;
    assign w_ctrl_load = w_ctrl & ex_mem_memread & w_match_mem;

    assign hazard      = w_load_use | w_ctrl_use | w_ctrl_load;
    assign two_bubbles = w_ctrl & w_load_use;

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_controller
//  Brief    : Pipeline stall/flush control with a two-state bubble FSM and
//             saturating stall/flush event counters.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_use_rs1,
    input  logic             IF_ID_use_rs2,
    input  logic             branch,
    input  logic             jal,
    input  logic             jalr,
    input  logic             branch_taken,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_regwrite,
    input  logic             ID_EX_memread,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             EX_MEM_memread,
    input  logic             ICACHE_stall,
    input  logic             DCACHE_stall,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             MEM_WB_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_hazard;
    logic             w_two_bubbles;
    logic             w_cache_stall;
    logic             w_redirect;

    hazard_detect u_detect (
        .if_id_rs1      (IF_ID_rs1),
        .if_id_rs2      (IF_ID_rs2),
        .if_id_use_rs1  (IF_ID_use_rs1),
        .if_id_use_rs2  (IF_ID_use_rs2),
        .branch         (branch),
        .jalr           (jalr),
        .id_ex_rd       (ID_EX_rd),
        .id_ex_regwrite (ID_EX_regwrite),
        .id_ex_memread  (ID_EX_memread),
        .ex_mem_rd      (EX_MEM_rd),
        .ex_mem_memread (EX_MEM_memread),
        .hazard         (w_hazard),
        .two_bubbles    (w_two_bubbles)
    );

    assign w_cache_stall = ICACHE_stall | DCACHE_stall;
    assign w_redirect    = jal | jalr | (branch & branch_taken);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        if (!rst_n) begin
            w_state_nxt  = RUN;
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
            ID_EX_bubble = 1'b1;
        end else if (w_cache_stall) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
        end else if (r_state == BUBBLE2) begin
            w_state_nxt  = RUN;
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
        end else if (w_hazard) begin
            // A control op waiting on a load needs the load through MEM too
            w_state_nxt  = w_two_bubbles ? BUBBLE2 : RUN;
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
        end else if (w_redirect) begin
            IF_ID_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (ID_EX_bubble && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (IF_ID_flush && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
